alu_seq_core: RTL and testbench

Parametrised successor to the 4-bit ALU/FSM pair. It assembles WIDTH-bit operands A and B and a 4-bit opcode from a narrow BUS_W-bit data bus, one beat per `ctl` strobe, then executes the operation and holds a registered result with carry and zero flags. It sits directly behind the chip-level pin mux. A persistent carry flag supports multi-word ADC/SBC chaining across operations.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_seq_core_alu_w.sv | 65 ++++++
 rtl/alu_seq_core.sv | 132 +++++++++++++
 tb/tb_alu_seq_core.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - state encoding and opcode constants for alu_seq_core
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_LOAD_A = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_LOAD_M = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_PASSB = 3'd5;
    localparam logic [2:0] OP_SHL   = 3'd6;
    localparam logic [2:0] OP_SHR   = 3'd7;

    localparam int OP_CHAIN_BIT = 3;

endpackage

// File: rtl/alu_seq_core_alu_w.sv
// rtl/alu_seq_core_alu_w.sv - combinational WIDTH-bit ALU slice used by alu_seq_core
module alu_w
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             cin,
    input  logic             cin_keep,
    output logic [WIDTH-1:0] y,
    output logic             co
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = '0;
        y   = b;
        co  = cin_keep;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                y   = sum[WIDTH-1:0];
                co  = sum[WIDTH];
            end
            // Subtract as A + ~B + cin so carry=1 reads as "no borrow".
            OP_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
                y   = sum[WIDTH-1:0];
                co  = sum[WIDTH];
            end
            OP_AND: begin
                y  = a & b;
                co = 1'b0;
            end
            OP_OR: begin
                y  = a | b;
                co = 1'b0;
            end
            OP_XOR: begin
                y  = a ^ b;
                co = 1'b0;
            end
            OP_PASSB: begin
                y  = b;
                co = cin_keep;
            end
            OP_SHL: begin
                y  = {a[WIDTH-2:0], 1'b0};
                co = a[WIDTH-1];
            end
            OP_SHR: begin
                y  = {1'b0, a[WIDTH-1:1]};
                co = a[0];
            end
            default: begin
                y  = b;
                co = cin_keep;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - beat-serial operand loader, FSM and registered ALU result with persistent carry
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BUS_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctl,
    input  logic [BUS_W-1:0] databus,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             done,
    output logic [2:0]       cur_state
);

    localparam int N  = WIDTH / BUS_W;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             zero_q;
    logic             done_q;

    logic             cin_d;
    logic [WIDTH-1:0] y_d;
    logic             co_d;

    // Unchained ADD starts with carry 0, unchained SUB with carry 1 (no borrow).
    always_comb begin
        cin_d = (op_q[2:0] == OP_SUB);
        if (op_q[OP_CHAIN_BIT]) begin
            cin_d = cout_q;
        end
    end

    alu_w #(.WIDTH(WIDTH)) u_alu (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q[2:0]),
        .cin      (cin_d),
        .cin_keep (cout_q),
        .y        (y_d),
        .co       (co_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_LOAD_A;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD_A: begin
                    if (ctl) begin
                        a_q[k_q*BUS_W +: BUS_W] <= databus;
                        if (k_q == K_LAST) begin
                            k_q     <= '0;
                            state_q <= ST_LOAD_B;
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (ctl) begin
                        b_q[k_q*BUS_W +: BUS_W] <= databus;
                        if (k_q == K_LAST) begin
                            k_q     <= '0;
                            state_q <= ST_LOAD_M;
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                end
                ST_LOAD_M: begin
                    if (ctl) begin
                        op_q    <= databus[3:0];
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q <= y_d;
                    cout_q   <= co_d;
                    zero_q   <= (y_d == '0);
                    done_q   <= 1'b1;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    // A strobe here is already beat 0 of the next A operand.
                    if (ctl) begin
                        a_q[BUS_W-1:0] <= databus;
                        done_q         <= 1'b0;
                        if (N == 1) begin
                            k_q     <= '0;
                            state_q <= ST_LOAD_B;
                        end else begin
                            k_q     <= KW'(1);
                            state_q <= ST_LOAD_A;
                        end
                    end
                end
                default: begin
                    k_q     <= '0;
                    done_q  <= 1'b0;
                    state_q <= ST_LOAD_A;
                end
            endcase
        end
    end

    assign result    = result_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign done      = done_q;
    assign cur_state = state_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - randomized self-checking bench for alu_seq_core against an arithmetic model
module tb_alu_seq_core;

    localparam int W  = 8;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ctl;
    logic [BW-1:0] databus;
    logic [W-1:0]  result;
    logic          cout;
    logic          zero;
    logic          done;
    logic [2:0]    cur_state;

    int total = 0;
    int bad   = 0;
    int gap_max = 0;

    int m_carry  = 0;
    int m_result = 0;
    int m_zero   = 0;

    alu_seq_core #(.WIDTH(W), .BUS_W(BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ctl       (ctl),
        .databus   (databus),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .done      (done),
        .cur_state (cur_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [3:0] v);
        int gaps;
        gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (gaps) begin
            ctl     = 1'b0;
            databus = BW'($urandom);
            @(negedge clk);
        end
        ctl     = 1'b1;
        databus = v;
        @(negedge clk);
        ctl = 1'b0;
    endtask

    task automatic model(input int a, input int b, input int m, output int r, output int c);
        int op;
        int cin;
        int s;
        op  = m % 8;
        cin = 0;
        case (op)
            0: begin
                cin = (m >= 8) ? m_carry : 0;
                s = a + b + cin;
                r = s % 256;
                c = (s > 255) ? 1 : 0;
            end
            1: begin
                cin = (m >= 8) ? m_carry : 1;
                s = a - b - (1 - cin);
                c = (s >= 0) ? 1 : 0;
                r = (s + 256) % 256;
            end
            2: begin r = a & b; c = 0; end
            3: begin r = a | b; c = 0; end
            4: begin r = a ^ b; c = 0; end
            5: begin r = b;     c = m_carry; end
            6: begin r = (a * 2) % 256; c = a / 128; end
            default: begin r = a / 2; c = a % 2; end
        endcase
        m_carry = c;
    endtask

    task automatic do_op(input int a, input int b, input int m, input bit exec_ctl, input string tag);
        int r;
        int c;
        model(a, b, m, r, c);
        beat(4'(a % 16));
        check({tag, "/hold_res"}, 32'(result), 32'(m_result));
        check({tag, "/hold_zero"}, 32'(zero), 32'(m_zero));
        check({tag, "/load_done"}, 32'(done), 32'd0);
        beat(4'(a / 16));
        beat(4'(b % 16));
        beat(4'(b / 16));
        beat(4'(m));
        check({tag, "/exec_state"}, 32'(cur_state), 32'd3);
        check({tag, "/exec_done"}, 32'(done), 32'd0);
        ctl     = exec_ctl;
        databus = BW'($urandom);
        @(negedge clk);
        ctl = 1'b0;
        check({tag, "/done_state"}, 32'(cur_state), 32'd4);
        check({tag, "/done"}, 32'(done), 32'd1);
        check({tag, "/result"}, 32'(result), 32'(r));
        check({tag, "/cout"}, 32'(cout), 32'(c));
        check({tag, "/zero"}, 32'(zero), (r == 0) ? 32'd1 : 32'd0);
        m_result = r;
        m_zero   = (r == 0) ? 1 : 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "/state"}, 32'(cur_state), 32'd0);
        check({tag, "/result"}, 32'(result), 32'd0);
        check({tag, "/cout"}, 32'(cout), 32'd0);
        check({tag, "/zero"}, 32'(zero), 32'd0);
        check({tag, "/done"}, 32'(done), 32'd0);
    endtask

    initial begin
        reset   = 1'b0;
        ctl     = 1'b0;
        databus = '0;
        repeat (3) @(negedge clk);
        check_reset_state("rst0");
        reset = 1'b1;

        do_op(8'h3C, 8'h5A, 0, 1'b0, "add96");
        do_op(8'h20, 8'h10, 1, 1'b1, "sub_nb");
        do_op(8'h10, 8'h20, 1, 1'b0, "sub_b");
        do_op(8'hFF, 8'h01, 0, 1'b1, "add_wrap");
        do_op(8'h00, 8'h00, 8, 1'b0, "adc");
        do_op(8'h81, 8'h00, 7, 1'b1, "shr");
        do_op(8'h81, 8'h00, 6, 1'b0, "shl");
        do_op(8'hF0, 8'hFF, 4, 1'b1, "xor");
        do_op(8'h12, 8'hA7, 5, 1'b1, "passb");

        // Abort mid-load: A fully loaded, B fully loaded, opcode never sent.
        beat(4'h1);
        beat(4'h2);
        beat(4'h3);
        beat(4'h4);
        reset = 1'b0;
        ctl   = 1'b0;
        @(negedge clk);
        check_reset_state("rst_mid");
        reset    = 1'b1;
        m_carry  = 0;
        m_result = 0;
        m_zero   = 0;
        do_op(8'h3C, 8'h5A, 0, 1'b0, "after_rst");

        gap_max = 3;
        for (int i = 0; i < 40; i++) begin
            do_op(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
                  int'($urandom_range(15, 0)), 1'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
